// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter_pkg
// Brief    : Shared owner-state encodings and default bus widths for ram_arbiter.
// Revision : 1.0
// ============================================================================
package ram_arbiter_pkg;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_ADDRESS_WIDTH = 4;
    localparam int BURST_CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_LDR  = 2'd2
    } owner_e;

    typedef enum logic {
        SIDE_CPU = 1'b0,
        SIDE_LDR = 1'b1
    } side_e;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Round-robin, burst-bounded arbiter sharing one synchronous RAM
//            between the CPU control path and the program loader.
// Revision : 1.0
// ============================================================================
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int MAX_BURST     = 4
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0]         cpu_wdata,
    output logic                     cpu_gnt,
    output logic                     cpu_rvalid,

    input  logic                     ldr_req,
    input  logic                     ldr_we,
    input  logic [ADDRESS_WIDTH-1:0] ldr_addr,
    input  logic [WIDTH-1:0]         ldr_wdata,
    input  logic                     ldr_lock,
    output logic                     ldr_gnt,
    output logic                     ldr_rvalid,

    output logic [WIDTH-1:0]         rdata,

    output logic                     ram_en,
    output logic                     ram_we,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0]         ram_wdata,
    input  logic [WIDTH-1:0]         ram_rdata,

    output logic                     cpu_hold
);

    localparam logic [BURST_CNT_W-1:0] BURST_MAX  = BURST_CNT_W'(MAX_BURST);
    localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(MAX_BURST - 1);

    owner_e                   state, state_next;
    side_e                    last, last_next;
    logic [BURST_CNT_W-1:0]   burst_cnt, burst_cnt_next;
    logic                     cpu_xfer, ldr_xfer, burst_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last       <= SIDE_LDR;
            burst_cnt  <= '0;
            cpu_rvalid <= 1'b0;
            ldr_rvalid <= 1'b0;
        end else begin
            state      <= state_next;
            last       <= last_next;
            burst_cnt  <= burst_cnt_next;
            cpu_rvalid <= cpu_xfer & ~cpu_we;
            ldr_rvalid <= ldr_xfer & ~ldr_we;
        end
    end

    always_comb begin
        cpu_xfer       = (state == ST_CPU) && cpu_req;
        ldr_xfer       = (state == ST_LDR) && ldr_req;
        // >= rather than == so a loader that drops lock after saturating still yields
        burst_done     = (burst_cnt >= BURST_LAST);
        state_next     = state;
        last_next      = last;
        burst_cnt_next = burst_cnt;

        if ((cpu_xfer || ldr_xfer) && (burst_cnt != BURST_MAX))
            burst_cnt_next = burst_cnt + 1'b1;

        case (state)
            ST_IDLE: begin
                if (cpu_req && ldr_req)
                    state_next = (last == SIDE_LDR) ? ST_CPU : ST_LDR;
                else if (cpu_req)
                    state_next = ST_CPU;
                else if (ldr_req)
                    state_next = ST_LDR;
            end
            ST_CPU: begin
                if (!cpu_req || (burst_done && ldr_req)) begin
                    state_next = ldr_req ? ST_LDR : ST_IDLE;
                    last_next  = SIDE_CPU;
                end
            end
            ST_LDR: begin
                if (!ldr_req || (burst_done && cpu_req && !ldr_lock)) begin
                    state_next = cpu_req ? ST_CPU : ST_IDLE;
                    last_next  = SIDE_LDR;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (state_next != state)
            burst_cnt_next = '0;
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state)
            ST_CPU: begin
                ram_en    = cpu_req;
                ram_we    = cpu_we & cpu_req;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
            end
            ST_LDR: begin
                ram_en    = ldr_req;
                ram_we    = ldr_we & ldr_req;
                ram_addr  = ldr_addr;
                ram_wdata = ldr_wdata;
            end
            default: ;
        endcase
    end

    assign cpu_gnt  = (state == ST_CPU);
    assign ldr_gnt  = (state == ST_LDR);
    assign cpu_hold = (state == ST_LDR);
    assign rdata    = ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Directed self-checking bench for ram_arbiter with a 16x8 RAM model.
// Revision : 1.0
// ============================================================================
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       ldr_req, ldr_we, ldr_lock, ldr_gnt, ldr_rvalid;
    logic [3:0] ldr_addr;
    logic [7:0] ldr_wdata;
    logic [7:0] rdata;
    logic       ram_en, ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = 8'h00;
    logic       cpu_hold;

    logic [7:0] mem [16];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    ram_arbiter #(.WIDTH(8), .ADDRESS_WIDTH(4), .MAX_BURST(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_lock   (ldr_lock),
        .ldr_gnt    (ldr_gnt),
        .ldr_rvalid (ldr_rvalid),
        .rdata      (rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .cpu_hold   (cpu_hold)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_cpu_gnt"},  {31'd0, cpu_gnt},    32'd0);
        check({tag, "_ldr_gnt"},  {31'd0, ldr_gnt},    32'd0);
        check({tag, "_cpu_rv"},   {31'd0, cpu_rvalid}, 32'd0);
        check({tag, "_ldr_rv"},   {31'd0, ldr_rvalid}, 32'd0);
        check({tag, "_ram_en"},   {31'd0, ram_en},     32'd0);
        check({tag, "_ram_we"},   {31'd0, ram_we},     32'd0);
        check({tag, "_ram_addr"}, {28'd0, ram_addr},   32'd0);
        check({tag, "_ram_wd"},   {24'd0, ram_wdata},  32'd0);
        check({tag, "_hold"},     {31'd0, cpu_hold},   32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 4'd0; cpu_wdata = 8'h00;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 4'd0; ldr_wdata = 8'h00;
        ldr_lock = 1'b0;

        // Reset then idle
        tick(); tick();
        check_quiet("rst");
        reset = 1'b0;
        tick(); tick();
        check_quiet("idle");

        // Loader writes mem[3] = A5
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'd3; ldr_wdata = 8'hA5;
        tick();
        check("wr_ldr_gnt",  {31'd0, ldr_gnt},  32'd1);
        check("wr_hold",     {31'd0, cpu_hold}, 32'd1);
        check("wr_ram_en",   {31'd0, ram_en},   32'd1);
        check("wr_ram_we",   {31'd0, ram_we},   32'd1);
        check("wr_ram_addr", {28'd0, ram_addr}, 32'd3);
        check("wr_ram_wd",   {24'd0, ram_wdata}, 32'hA5);
        tick();
        check("wr_no_rv", {31'd0, ldr_rvalid}, 32'd0);
        ldr_req = 1'b0; ldr_we = 1'b0;
        tick();
        check("wr_done_gnt", {31'd0, ldr_gnt}, 32'd0);

        // Single CPU read of addr 3
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd3;
        tick();
        check("rd_cpu_gnt", {31'd0, cpu_gnt},    32'd1);
        check("rd_rv_early", {31'd0, cpu_rvalid}, 32'd0);
        tick();
        cpu_req = 1'b0;
        check("rd_cpu_rv",  {31'd0, cpu_rvalid}, 32'd1);
        check("rd_rdata",   {24'd0, rdata},      32'hA5);
        check("rd_ldr_rv",  {31'd0, ldr_rvalid}, 32'd0);
        tick();
        check("rd_rv_once", {31'd0, cpu_rvalid}, 32'd0);
        check("rd_gnt_off", {31'd0, cpu_gnt},    32'd0);

        // Simultaneous requests after reset: CPU first, 4 and 4, no gap
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd3;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 4'd3;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("rr_cpu_gnt_%0d", i), {31'd0, cpu_gnt},
                  {31'd0, (i <= 4) || (i == 9)});
            check($sformatf("rr_ldr_gnt_%0d", i), {31'd0, ldr_gnt},
                  {31'd0, (i >= 5) && (i <= 8)});
            check($sformatf("rr_hold_%0d", i), {31'd0, cpu_hold},
                  {31'd0, (i >= 5) && (i <= 8)});
            check($sformatf("rr_cpu_rv_%0d", i), {31'd0, cpu_rvalid},
                  {31'd0, (i >= 2) && (i <= 5)});
            check($sformatf("rr_ldr_rv_%0d", i), {31'd0, ldr_rvalid},
                  {31'd0, (i >= 6) && (i <= 9)});
            if (i >= 2)
                check($sformatf("rr_rdata_%0d", i), {24'd0, rdata}, 32'hA5);
        end

        // Reset in the middle of a CPU read burst
        tick();
        check("mid_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
        reset = 1'b1;
        tick();
        check("mid_cpu_gnt0", {31'd0, cpu_gnt},    32'd0);
        check("mid_ldr_gnt0", {31'd0, ldr_gnt},    32'd0);
        check("mid_cpu_rv0",  {31'd0, cpu_rvalid}, 32'd0);
        check("mid_ram_en0",  {31'd0, ram_en},     32'd0);
        reset = 1'b0;
        tick();
        check("post_cpu_win", {31'd0, cpu_gnt}, 32'd1);
        check("post_ldr_off", {31'd0, ldr_gnt}, 32'd0);
        cpu_req = 1'b0; ldr_req = 1'b0;
        tick();
        check("post_idle", {31'd0, cpu_gnt | ldr_gnt}, 32'd0);

        // Locked loader burst of 16 writes while the CPU waits
        ldr_lock = 1'b1;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'd0; ldr_wdata = 8'h10;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd0;
        tick();
        for (int i = 0; i < 16; i++) begin
            ldr_addr  = 4'(i);
            ldr_wdata = 8'(8'h10 + i);
            #1;
            check($sformatf("lk_gnt_%0d", i),  {31'd0, ldr_gnt & ~cpu_gnt}, 32'd1);
            check($sformatf("lk_hold_%0d", i), {31'd0, cpu_hold},          32'd1);
            check($sformatf("lk_addr_%0d", i), {28'd0, ram_addr},          i);
            check($sformatf("lk_wd_%0d", i),   {24'd0, ram_wdata},         32'h10 + i);
            tick();
        end
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_lock = 1'b0;
        check("lk_cpu_wait", {31'd0, cpu_gnt}, 32'd0);
        tick();
        check("lk_cpu_gnt",  {31'd0, cpu_gnt},  32'd1);
        check("lk_hold_off", {31'd0, cpu_hold}, 32'd0);
        tick();
        check("lk_rd0_rv", {31'd0, cpu_rvalid}, 32'd1);
        check("lk_rd0",    {24'd0, rdata},      32'h10);
        cpu_addr = 4'd15;
        tick();
        check("lk_rd15_rv", {31'd0, cpu_rvalid}, 32'd1);
        check("lk_rd15",    {24'd0, rdata},      32'h1F);
        cpu_req = 1'b0;
        tick();
        tick();
        check("end_idle", {31'd0, cpu_gnt | ldr_gnt | ram_en}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
